uart_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the single UART transmit byte stream between NUM_REQ requesters (telemetry, debug, command responses).
- Each granted packet goes out as a framed sequence: one header byte identifying the source, then the payload bytes, then an optional checksum byte.
- Sits between the requester logic and the UART data_in/valid/ready interface. Owns the output byte register that feeds the transmitter.

---
 rtl/uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART transmit byte stream.
// Optional checksum trailer byte when UART_TX_ARB_CHECKSUM_EN is defined.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_data/valid/last    per-requester byte stream (8 bits per requester)
//   req_ready              per-requester byte accept
//   uart_data/valid/ready  registered byte handshake toward the transmitter
//   grant_id               current or most recent grantee
//   busy                   high whenever the FSM is not idle
//   truncated              one-cycle pulse on a packet cut at MAX_LEN
module uart_tx_arbiter #(
  parameter int         NUM_REQ    = 4,
  parameter logic [3:0] HEADER_TAG = 4'hA,
  parameter int         MAX_LEN    = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_valid,
  input  logic                 uart_ready,
  output logic [3:0]           grant_id,
  output logic                 busy,
  output logic                 truncated
);

  localparam logic [15:0] MAXL = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef UART_TX_ARB_CHECKSUM_EN
    S_CSUM,
`endif
    S_PAYLOAD
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  grant_q;
  logic [3:0]  rr_q;
  logic [15:0] len_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        trunc_q;
`ifdef UART_TX_ARB_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        out_free;
  logic        sel_found;
  logic [3:0]  sel_idx;
  logic [3:0]  rr_d;
  logic        g_valid;
  logic        g_last;
  logic [7:0]  g_data;
  logic        accept;
  logic        load_en;
  logic [7:0]  load_byte;
  logic [15:0] len_inc;
  logic        hit_max;

  assign out_free   = !valid_q || uart_ready;
  assign len_inc    = len_q + 16'd1;
  assign hit_max    = (len_inc == MAXL);
  assign uart_data  = data_q;
  assign uart_valid = valid_q;
  assign grant_id   = grant_q;
  assign truncated  = trunc_q;
  assign rr_d       = 4'((int'(sel_idx) + 1) % NUM_REQ);

  // Walk offsets downward so the smallest offset from rr_q wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(rr_q) + k) % NUM_REQ && req_valid[i]) begin
          sel_found = 1'b1;
          sel_idx   = 4'(i);
        end
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 4'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found && out_free) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (accept && (g_last || hit_max)) begin
`ifdef UART_TX_ARB_CHECKSUM_EN
          // A forced cut still closes its frame with a checksum.
          state_d = S_CSUM;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      S_CSUM: begin
        if (out_free) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    load_en   = 1'b0;
    load_byte = '0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (sel_found && out_free) begin
          load_en   = 1'b1;
          load_byte = {HEADER_TAG, sel_idx};
        end
      end
      S_PAYLOAD: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == 4'(i)) req_ready[i] = out_free;
        end
        accept = g_valid && out_free;
        if (accept) begin
          load_en   = 1'b1;
          load_byte = g_data;
        end
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      S_CSUM: begin
        if (out_free) begin
          load_en   = 1'b1;
          load_byte = csum_q;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      trunc_q <= 1'b0;
      grant_q <= '0;
      rr_q    <= '0;
      len_q   <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      // Register only moves when the transmitter has taken its byte.
      if (out_free) begin
        valid_q <= load_en;
        if (load_en) data_q <= load_byte;
      end
      trunc_q <= accept && !g_last && hit_max;
      if (state_q == S_IDLE && load_en) begin
        grant_q <= sel_idx;
        rr_q    <= rr_d;
        len_q   <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
        csum_q  <= load_byte;
`endif
      end else if (accept) begin
        len_q   <= len_inc;
`ifdef UART_TX_ARB_CHECKSUM_EN
        csum_q  <= csum_q ^ g_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (MAX_LEN overridden to 4).
// Frames on the UART side are parsed against per-requester byte queues.
module tb_uart_tx_arbiter;

  localparam int MAXL = 4;
`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam int CSB = 1;
`else
  localparam int CSB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] req_data = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ready = 1'b1;
  logic [3:0]  grant_id;
  logic        busy;
  logic        truncated;

  uart_tx_arbiter #(
    .NUM_REQ(4), .HEADER_TAG(4'hA), .MAX_LEN(MAXL)
  ) dut (
    .clk(clk), .reset(reset),
    .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready),
    .uart_data(uart_data), .uart_valid(uart_valid),
    .uart_ready(uart_ready), .grant_id(grant_id),
    .busy(busy), .truncated(truncated)
  );

  always #5 clk = ~clk;

  logic [8:0] rq [4][$];
  logic [8:0] ex [4][$];
  logic [7:0] rx [$];
  logic [7:0] hq [$];
  int   checks = 0;
  int   errors = 0;
  int   tcount = 0;
  int   ready_mode = 0;
  bit   stall_rand = 0;
  bit   rst_req = 1;
  logic [3:0] stall = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    rq[s].push_back({l, d});
    ex[s].push_back({l, d});
  endtask

  task automatic cycle();
    @(negedge clk);
    reset = rst_req;
    if (stall_rand) stall = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0 && !stall[i]) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i] = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
    case (ready_mode)
      1: uart_ready = ($urandom_range(0, 9) < 7);
      2: uart_ready = 1'b0;
      default: uart_ready = 1'b1;
    endcase
    #1;
    if (truncated) tcount++;
    if (!reset) begin
      if (uart_valid && uart_ready) rx.push_back(uart_data);
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
    end
  endtask

  function automatic bit idle_now();
    return rq[0].size() == 0 && rq[1].size() == 0 &&
           rq[2].size() == 0 && rq[3].size() == 0 &&
           !uart_valid && !busy;
  endfunction

  task automatic drain(input int maxc);
    int c = 0;
    stall_rand = 0;
    stall = '0;
    while (!idle_now() && c < maxc) begin
      cycle();
      c++;
    end
    chk("drain", 32'(idle_now()), 1);
  endtask

  task automatic wait_rx(input int n);
    int c = 0;
    while (rx.size() < n && c < 200) begin
      cycle();
      c++;
    end
    chk("wait_rx", 32'(rx.size() >= n), 1);
  endtask

  // Frame = header, then the source's bytes up to last or MAXL,
  // then (optionally) XOR of everything in the frame.
  task automatic check_frames();
    logic [7:0] h, b, cs;
    logic [8:0] e;
    int s, n;
    bit done;
    while (rx.size() > 0) begin
      h = rx.pop_front();
      hq.push_back(h);
      chk("hdr_tag", 32'(h[7:4]), 32'hA);
      s = int'(h[3:0]);
      chk("hdr_src", 32'(s < 4), 1);
      if (s >= 4) return;
      cs = h;
      n = 0;
      done = 0;
      while (!done) begin
        chk("frame_avail", 32'(rx.size() > 0 && ex[s].size() > 0), 1);
        if (rx.size() == 0 || ex[s].size() == 0) return;
        e = ex[s].pop_front();
        b = rx.pop_front();
        chk("payload", 32'(b), 32'(e[7:0]));
        cs ^= b;
        n++;
        done = e[8] || n == MAXL;
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      chk("csum_avail", 32'(rx.size() > 0), 1);
      if (rx.size() == 0) return;
      b = rx.pop_front();
      chk("checksum", 32'(b), 32'(cs));
`endif
    end
    for (int i = 0; i < 4; i++) chk("leftover", ex[i].size(), 0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      rq[i].delete();
      ex[i].delete();
    end
    rx.delete();
    hq.delete();
  endtask

  initial begin
    logic [7:0] exp1 [4];
    logic [7:0] hd;
    logic hv;
    int exp_trunc, len, s, npk;
    exp1 = '{8'hA2, 8'h11, 8'h22, 8'h91};

    rst_req = 1;
    repeat (3) cycle();
    rst_req = 0;
    cycle();
    chk("rst_valid", 32'(uart_valid), 0);
    chk("rst_data", 32'(uart_data), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_trunc", 32'(truncated), 0);

    push(2, 8'h11, 0);
    push(2, 8'h22, 1);
    drain(200);
    chk("single_len", rx.size(), 3 + CSB);
    for (int k = 0; k < 3 + CSB; k++)
      if (k < rx.size()) chk("single_byte", 32'(rx[k]), 32'(exp1[k]));
    check_frames();

    rst_req = 1;
    cycle();
    rst_req = 0;
    clear_all();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) push(i, 8'(8'h40 + 8*r + i), 1);
    drain(400);
    check_frames();
    chk("cont_hdrs", hq.size(), 8);
    for (int k = 0; k < 5; k++)
      if (k < hq.size()) chk("cont_order", 32'(hq[k]), 32'({4'hA, 4'(k % 4)}));

    clear_all();
    tcount = 0;
    for (int k = 0; k < 4; k++) push(0, 8'(8'h50 + k), k == 3);
    wait_rx(3);
    ready_mode = 2;
    cycle();
    hd = uart_data;
    hv = uart_valid;
    chk("bp_valid", 32'(hv), 1);
    chk("bp_ready", 32'(req_ready), 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("bp_data", 32'(uart_data), 32'(hd));
      chk("bp_vhold", 32'(uart_valid), 1);
      chk("bp_ready", 32'(req_ready), 0);
    end
    ready_mode = 0;
    drain(200);
    chk("bp_notrunc", tcount, 0);
    check_frames();

    clear_all();
    tcount = 0;
    for (int k = 1; k <= 6; k++) push(1, 8'(8'hB0 + k), k == 6);
    drain(200);
    chk("trunc_pulse", tcount, 1);
    check_frames();
    chk("trunc_frames", hq.size(), 2);
    for (int k = 0; k < 2; k++)
      if (k < hq.size()) chk("trunc_hdr", 32'(hq[k]), 32'hA1);

    clear_all();
    for (int k = 0; k < 3; k++) push(2, 8'(8'hC0 + k), k == 2);
    wait_rx(2);
    rst_req = 1;
    cycle();
    rst_req = 0;
    clear_all();
    push(3, 8'hD3, 1);
    push(0, 8'hD0, 1);
    cycle();
    chk("mid_rst_valid", 32'(uart_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    drain(200);
    check_frames();
    if (hq.size() > 0) chk("mid_rst_first", 32'(hq[0]), 32'hA0);

    clear_all();
    for (int k = 0; k < 3; k++) push(0, 8'(8'hE0 + k), k == 2);
    push(1, 8'hE8, 0);
    push(1, 8'hE9, 1);
    wait_rx(2);
    stall = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("stall_grant", 32'(grant_id), 0);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_ready1", 32'(req_ready[1]), 0);
    end
    drain(200);
    check_frames();
    chk("stall_frames", hq.size(), 2);
    if (hq.size() >= 2) begin
      chk("stall_hdr0", 32'(hq[0]), 32'hA0);
      chk("stall_hdr1", 32'(hq[1]), 32'hA1);
    end

    for (int r = 0; r < 25; r++) begin
      clear_all();
      tcount = 0;
      exp_trunc = 0;
      npk = $urandom_range(1, 4);
      for (int p = 0; p < npk; p++) begin
        s = $urandom_range(0, 3);
        len = $urandom_range(1, 7);
        exp_trunc += (len - 1) / MAXL;
        for (int k = 0; k < len; k++)
          push(s, 8'($urandom_range(0, 255)), k == len - 1);
      end
      ready_mode = 1;
      stall_rand = 1;
      repeat (30) cycle();
      drain(3000);
      ready_mode = 0;
      chk("rand_trunc", tcount, exp_trunc);
      check_frames();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
